present_drop_controller: RTL
============================

// Module: present_drop_controller
// PURPOSE
//  Consumer of the latched-counter random source. On a spawn request it pulses rand_rise, captures the random value, and spawns one present.
//  The captured value sets the present X position and type. The present falls one step per frame, rests on the floor, then expires.
//  It leaves play early if the player collects it. Sits between the game logic (spawn/collision) and the present drawing/bonus logic.
// PARAMETERS
//  RAND_BITS   10   width of rand_val from the random source
//  X_MIN       8    leftmost legal present X (pixels)
//  X_MAX       600  rightmost legal present X (pixels)
//  SPAWN_Y     16   Y loaded at spawn
//  FLOOR_Y     440  resting Y
//  FALL_SPEED  2    pixels per frame (initial speed when gravity enabled)
//  MAX_SPEED   8    speed cap (gravity option only)
//  ACCEL_FRAMES 4   frames between speed increments (gravity option only)
//  LAND_FRAMES 120  frames a landed present stays before expiring
// PORTS
//  clk           in   1          system clock
//  reset         in   1          asynchronous, active-high reset
//  startOfFrame  in   1          one-cycle pulse per video frame
//  spawn_req     in   1          one-cycle request to drop a present
//  rand_val      in   RAND_BITS  dout of the random source
//  collected     in   1          present/player collision (level, sampled each clk)
//  rand_rise     out  1          drives rise of the random source
//  present_on    out  1          present exists (FALL or LAND)
//  present_x     out  11         top-left X
//  present_y     out  11         top-left Y
//  present_type  out  2          bonus kind = captured rand_val[1:0]
//  bonus_pulse   out  1          one-cycle pulse on collection
//  busy          out  1          state != IDLE
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE; every output 0; internal counters 0. Reset mid-fall removes the present immediately.
//  IDLE: spawn_req=1 -> REQ. While busy, spawn_req is ignored (no queueing).
//  REQ (1 clk): rand_rise=1 -> WAIT. WAIT (1 clk): rand_rise=0 -> CAPTURE.
//   The source latches dout on the rise edge. rand_val is therefore stable by CAPTURE.
//   rand_rise is a registered output: it is high for exactly one cycle, and low-to-high only once per spawn.
//  CAPTURE (1 clk): v = rand_val zero-extended to 11 bits.
//   x = v if X_MIN<=v<=X_MAX.
//   x = v-(X_MAX-X_MIN+1) if v>X_MAX, then clamped to X_MAX if the result is still >X_MAX.
//   x = X_MIN if v<X_MIN.
//   type=v[1:0]; y=SPAWN_Y; present_on=1 -> FALL.
//   Spawn-to-visible latency: 3 clk after the spawn_req cycle.
//  FALL: on each startOfFrame, if y+speed >= FLOOR_Y then y=FLOOR_Y and -> LAND (frame counter cleared); else y += speed.
//   All Y arithmetic is 11-bit unsigned; no wrap is possible because of the clamp to FLOOR_Y.
//  LAND: frame counter increments on each startOfFrame. When the counter reaches LAND_FRAMES-1 on a startOfFrame: present_on=0 -> IDLE (no bonus).
//  Collection: collected=1 in FALL or LAND -> bonus_pulse=1 for 1 clk, present_on=0 -> IDLE next clk.
//   Collection has priority over landing/expiry in the same cycle. collected is ignored in IDLE/REQ/WAIT/CAPTURE.
//  present_x and present_type hold their values after the present is removed until the next CAPTURE. present_y is held likewise.
// CONFIGURATION
//  PRESENT_GRAVITY_EN defined: speed starts at FALL_SPEED on CAPTURE.
//   speed increments by 1 every ACCEL_FRAMES startOfFrame pulses while in FALL, saturating at MAX_SPEED.
//   speed and accel counter reset at each CAPTURE.
//  Not defined: constant speed FALL_SPEED; no accel counter or speed register is synthesized.
// TESTING
//  1 Reset: assert reset mid-FALL (y=100) -> all outputs 0 asynchronously, state IDLE; spawn after release works normally.
//  2 Handshake: spawn_req at cycle t, rand_val=300 -> rand_rise=1 only at t+1; x=300, type=0, y=16, present_on=1 at t+3.
//  3 X range: rand_val=1000 -> x=1000-593=407; rand_val=3 -> x=8; rand_val=600 -> x=600; type=rand_val[1:0] in each case.
//  4 Fall/land/expire (no macro): 212 frames after spawn y=440 and state=LAND.
//    Check y=438 after 211 frames; present_on drops after 120 further frames; bonus_pulse never fires.
//  5 Collect: collected=1 in the same cycle as the landing frame -> one bonus_pulse, present_on=0, no LAND.
//    spawn_req while busy is ignored (rand_rise stays 0).
//  6 PRESENT_GRAVITY_EN: speed sequence per frame is 2,2,2,2,3,3,3,3,4,...; it saturates at 8.
//    Landing is still clamped to exactly y=440.

Source files
------------

// File: rtl/present_drop_controller.sv
// rtl/present_drop_controller.sv - spawns one falling present from a latched random value
//
// Purpose:
//   Spawn handshake with the latched-counter random source (rand_rise pulse, then
//   capture of rand_val), then one present that falls a step per frame, rests on
//   the floor and expires, or leaves early when the player collects it.
//
// Optional feature macro: PRESENT_GRAVITY_EN
//   defined   : fall speed starts at FALL_SPEED and grows by 1 every ACCEL_FRAMES
//               frames, saturating at MAX_SPEED
//   undefined : constant fall speed FALL_SPEED, no speed/accel registers
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   startOfFrame  one-cycle pulse per video frame
//   spawn_req     one-cycle request to drop a present (ignored while busy)
//   rand_val      dout of the random source
//   collected     present/player collision level
//   rand_rise     one-cycle pulse to the random source rise input
//   present_on    present exists (falling or landed)
//   present_x     top-left X
//   present_y     top-left Y
//   present_type  bonus kind, low two bits of the captured value
//   bonus_pulse   one-cycle pulse on collection
//   busy          controller not idle

module present_drop_controller #(
    parameter int RAND_BITS    = 10,
    parameter int X_MIN        = 8,
    parameter int X_MAX        = 600,
    parameter int SPAWN_Y      = 16,
    parameter int FLOOR_Y      = 440,
    parameter int FALL_SPEED   = 2,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4,
    parameter int LAND_FRAMES  = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 spawn_req,
    input  logic [RAND_BITS-1:0] rand_val,
    input  logic                 collected,
    output logic                 rand_rise,
    output logic                 present_on,
    output logic [10:0]          present_x,
    output logic [10:0]          present_y,
    output logic [1:0]           present_type,
    output logic                 bonus_pulse,
    output logic                 busy
);

    localparam int CNT_MAX = (LAND_FRAMES > ACCEL_FRAMES) ? LAND_FRAMES : ACCEL_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [10:0] X_MIN_V   = 11'(X_MIN);
    localparam logic [10:0] X_MAX_V   = 11'(X_MAX);
    localparam logic [10:0] X_SPAN_V  = 11'(X_MAX - X_MIN + 1);
    localparam logic [10:0] SPAWN_Y_V = 11'(SPAWN_Y);
    localparam logic [10:0] FLOOR_Y_V = 11'(FLOOR_Y);
    localparam logic [CNT_W-1:0] LAND_LAST = CNT_W'(LAND_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAPTURE,
        S_FALL,
        S_LAND
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  land_cnt;
    logic [10:0]       cur_speed;
    logic [10:0]       y_step;
    logic [10:0]       v;

    // Out-of-range values above X_MAX fold back by one span; anything still
    // too large is pinned to the right edge.
    function automatic logic [10:0] map_x(input logic [10:0] val);
        logic [10:0] folded;
        folded = val - X_SPAN_V;
        if (val < X_MIN_V)
            return X_MIN_V;
        else if (val <= X_MAX_V)
            return val;
        else if (folded > X_MAX_V)
            return X_MAX_V;
        else
            return folded;
    endfunction

    assign v      = 11'(rand_val);
    assign y_step = present_y + cur_speed;
    assign busy   = (state != S_IDLE);

`ifdef PRESENT_GRAVITY_EN
    localparam int SPD_W = $clog2(MAX_SPEED + 1);
    localparam logic [SPD_W-1:0] SPD_INIT  = SPD_W'(FALL_SPEED);
    localparam logic [SPD_W-1:0] SPD_MAX   = SPD_W'(MAX_SPEED);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACCEL_FRAMES - 1);

    logic [SPD_W-1:0] speed;
    logic [CNT_W-1:0] accel_cnt;

    assign cur_speed = 11'(speed);
`else
    // Constant speed; the cap keeps a mis-set FALL_SPEED within MAX_SPEED.
    assign cur_speed = 11'((FALL_SPEED > MAX_SPEED) ? MAX_SPEED : FALL_SPEED);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            land_cnt     <= '0;
            rand_rise    <= 1'b0;
            present_on   <= 1'b0;
            present_x    <= '0;
            present_y    <= '0;
            present_type <= '0;
            bonus_pulse  <= 1'b0;
`ifdef PRESENT_GRAVITY_EN
            speed        <= '0;
            accel_cnt    <= '0;
`endif
        end else begin
            bonus_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (spawn_req) begin
                        rand_rise <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    rand_rise <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // The source latched dout on the rise edge, so rand_val is
                    // already stable here; registering now makes the present
                    // visible in the CAPTURE cycle.
                    present_x    <= map_x(v);
                    present_type <= v[1:0];
                    present_y    <= SPAWN_Y_V;
                    present_on   <= 1'b1;
`ifdef PRESENT_GRAVITY_EN
                    speed        <= SPD_INIT;
                    accel_cnt    <= '0;
`endif
                    state        <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state <= S_FALL;
                end
                S_FALL: begin
                    if (collected) begin
                        bonus_pulse <= 1'b1;
                        present_on  <= 1'b0;
                        state       <= S_IDLE;
                    end else if (startOfFrame) begin
                        if (y_step >= FLOOR_Y_V) begin
                            present_y <= FLOOR_Y_V;
                            land_cnt  <= '0;
                            state     <= S_LAND;
                        end else begin
                            present_y <= y_step;
                        end
`ifdef PRESENT_GRAVITY_EN
                        if (accel_cnt == ACC_LAST) begin
                            accel_cnt <= '0;
                            if (speed < SPD_MAX)
                                speed <= speed + 1'b1;
                        end else begin
                            accel_cnt <= accel_cnt + 1'b1;
                        end
`endif
                    end
                end
                S_LAND: begin
                    if (collected) begin
                        bonus_pulse <= 1'b1;
                        present_on  <= 1'b0;
                        state       <= S_IDLE;
                    end else if (startOfFrame) begin
                        if (land_cnt == LAND_LAST) begin
                            present_on <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            land_cnt <= land_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    rand_rise  <= 1'b0;
                    present_on <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
